// File: rtl/first_system_decoder_if.sv
// Link between the first_system encoder stream and the word-wide consumer.
interface first_system_decoder_if #(
    parameter int unsigned PAIRS = 4
);
    logic                 enc1;
    logic                 enc2;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*PAIRS-1:0]   word_out;
    logic                 word_valid;
    logic                 word_ready;
    logic [4:0]           pair_cnt;

    // Upstream side: supplies encoded pairs and consumes words.
    modport master (
        output enc1, enc2, in_valid, word_ready,
        input  in_ready, word_out, word_valid, pair_cnt
    );

    // Decoder side.
    modport slave (
        input  enc1, enc2, in_valid, word_ready,
        output in_ready, word_out, word_valid, pair_cnt
    );
endinterface

// File: rtl/first_system_decoder.sv
// Decodes first_system pairs and packs PAIRS of them into one output word.
module first_system_decoder #(
    parameter int unsigned PAIRS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    first_system_decoder_if.slave  bus
);
    localparam int unsigned WORD_W = 2 * PAIRS;
    localparam int unsigned ACC_W  = 2 * (PAIRS - 1);
    localparam int unsigned CNT_W  = 5;

    // The output register is the FSM: EMPTY or holding a complete word.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    // Only slots 0..PAIRS-2 are ever stored; the last pair goes straight to word_out.
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_nxt;

    logic [1:0]        pair;
    logic              last;
    logic              in_fire;
    logic              out_fire;
    logic              complete;

    // Invert the encoding: d_in2 = ~enc2, d_in1 = enc1 ^ d_in2.
    always_comb begin
        pair    = 2'b00;
        pair[0] = ~bus.enc2;
        pair[1] = bus.enc1 ^ ~bus.enc2;
    end

    assign last     = (cnt == CNT_W'(PAIRS - 1));
    assign bus.in_ready = ~(last && (state == ST_FULL) && ~bus.word_ready);
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = (state == ST_FULL) && bus.word_ready;
    assign complete = in_fire && last;

    // Next-state and datapath update for accumulator, counter and output word.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        word_nxt  = word_q;
        if (complete) begin
            // A completing word always (re)fills the output, even while it drains.
            word_nxt  = {pair, acc};
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_FULL;
        end else begin
            if (in_fire) begin
                for (int unsigned k = 0; k < PAIRS - 1; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        acc_nxt[2*k +: 2] = pair;
                    end
                end
                cnt_nxt = cnt + CNT_W'(1);
            end
            if (out_fire) begin
                state_nxt = ST_EMPTY;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, pair counter and output word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            word_q <= '0;
        end else begin
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            word_q <= word_nxt;
        end
    end

    assign bus.word_valid = (state == ST_FULL);
    assign bus.word_out   = word_q;
    assign bus.pair_cnt   = cnt;
endmodule

// File: tb/tb_first_system_decoder.sv
// Directed bench for first_system_decoder with PAIRS = 4.
module tb_first_system_decoder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    first_system_decoder_if #(.PAIRS(4)) bus ();

    first_system_decoder #(.PAIRS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one pair and return just after the edge that accepts it.
    task automatic send_pair(input logic e1, input logic e2);
        int n;
        n = 0;
        bus.enc1     = e1;
        bus.enc2     = e2;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Encoded pairs for three back-to-back words: FF, AA, 36.
    logic [1:0] b2b_enc [12];
    logic [7:0] b2b_word [3];
    logic [1:0] ex_enc [4];
    logic [7:0] ex_word [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) begin
            b2b_enc[i]     = 2'b00;
            b2b_enc[4 + i] = 2'b11;
        end
        b2b_enc[8]  = 2'b11;
        b2b_enc[9]  = 2'b10;
        b2b_enc[10] = 2'b00;
        b2b_enc[11] = 2'b01;
        b2b_word[0] = 8'hFF;
        b2b_word[1] = 8'hAA;
        b2b_word[2] = 8'h36;
        ex_enc[0] = 2'b01; ex_word[0] = 8'h00;
        ex_enc[1] = 2'b10; ex_word[1] = 8'h55;
        ex_enc[2] = 2'b11; ex_word[2] = 8'hAA;
        ex_enc[3] = 2'b00; ex_word[3] = 8'hFF;

        // Reset with a live input request.
        rst            = 1'b1;
        bus.enc1       = 1'b1;
        bus.enc2       = 1'b0;
        bus.in_valid   = 1'b1;
        bus.word_ready = 1'b1;
        tick();
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_pair_cnt",   32'(bus.pair_cnt),   32'd0);
        check("rst_word_out",   32'(bus.word_out),   32'd0);
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        tick();

        // Single word.
        send_pair(1'b1, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b0);
        check("single_pre_valid", 32'(bus.word_valid), 32'd0);
        send_pair(1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("single_valid", 32'(bus.word_valid), 32'd1);
        check("single_word",  32'(bus.word_out),   32'h36);
        check("single_cnt",   32'(bus.pair_cnt),   32'd0);
        tick();
        @(negedge clk);
        check("single_drained", 32'(bus.word_valid), 32'd0);
        check("single_hold",    32'(bus.word_out),   32'h36);
        tick();

        // Backpressure: first word held, eighth pair stalled.
        bus.word_ready = 1'b0;
        send_pair(1'b1, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b0);
        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b0);
        bus.enc1     = 1'b1;
        bus.enc2     = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready),   32'd0);
            check("bp_valid",    32'(bus.word_valid), 32'd1);
            check("bp_word",     32'(bus.word_out),   32'h36);
            check("bp_cnt",      32'(bus.pair_cnt),   32'd3);
            tick();
        end
        bus.word_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid   = 1'b0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(bus.word_valid), 32'd1);
        check("bp_second_word",  32'(bus.word_out),   32'h55);
        check("bp_second_cnt",   32'(bus.pair_cnt),   32'd0);
        tick();
        bus.word_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_drained", 32'(bus.word_valid), 32'd0);
        check("bp_hold",    32'(bus.word_out),   32'h55);
        tick();

        // Back-to-back words with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            bus.enc1     = b2b_enc[i][1];
            bus.enc2     = b2b_enc[i][0];
            bus.in_valid = 1'b1;
            @(negedge clk);
            check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            check("b2b_valid", 32'(bus.word_valid), (i > 0 && i % 4 == 0) ? 32'd1 : 32'd0);
            if (i > 0 && i % 4 == 0) check("b2b_word", 32'(bus.word_out), 32'(b2b_word[i/4 - 1]));
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", 32'(bus.word_valid), 32'd1);
        check("b2b_last_word",  32'(bus.word_out),   32'(b2b_word[2]));
        tick();

        // Reset mid-word discards the partial pairs.
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_cnt_pre", 32'(bus.pair_cnt), 32'd2);
        tick();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_cnt_rst", 32'(bus.pair_cnt), 32'd0);
        tick();
        send_pair(1'b0, 1'b1);
        send_pair(1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_no_early_word", 32'(bus.word_valid), 32'd0);
        check("mid_cnt_two",       32'(bus.pair_cnt),   32'd2);
        // Idle bus garbage must not be consumed.
        bus.enc1 = 1'b1;
        bus.enc2 = 1'b1;
        tick();
        @(negedge clk);
        check("mid_idle_cnt", 32'(bus.pair_cnt), 32'd2);
        tick();
        send_pair(1'b0, 1'b1);
        send_pair(1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_valid", 32'(bus.word_valid), 32'd1);
        check("mid_word",  32'(bus.word_out),   32'h00);
        tick();

        // Every encoding repeated across a full word.
        for (int e = 0; e < 4; e++) begin
            for (int p = 0; p < 4; p++) send_pair(ex_enc[e][1], ex_enc[e][0]);
            bus.in_valid = 1'b0;
            @(negedge clk);
            check("ex_valid", 32'(bus.word_valid), 32'd1);
            check("ex_word",  32'(bus.word_out),   32'(ex_word[e]));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
